// File: rtl/hvsync_pkg.sv
// Shared timing defaults and coordinate type for the VGA sync generator.
// Defining HVSYNC_ACTIVE_HIGH_EN makes hsync/vsync active-high; by default they are active-low.
package hvsync_pkg;

    typedef logic [9:0] coord_t;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

`ifdef HVSYNC_ACTIVE_HIGH_EN
    localparam logic SYNC_ACTIVE = 1'b1;
`else
    localparam logic SYNC_ACTIVE = 1'b0;
`endif
    localparam logic SYNC_IDLE = ~SYNC_ACTIVE;

endpackage

// File: rtl/hvsync_axis.sv
// One timing axis: wrapping position counter with sync-pulse and visible-window decode.
// Sync polarity follows HVSYNC_ACTIVE_HIGH_EN through hvsync_pkg.
module hvsync_axis
    import hvsync_pkg::*;
#(
    parameter int DISPLAY = H_DISPLAY_DEF,
    parameter int FRONT   = H_FRONT_DEF,
    parameter int SYNC    = H_SYNC_DEF,
    parameter int BACK    = H_BACK_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [9:0] pos,
    output logic       sync,
    output logic       active,
    output logic       wrap
);

    localparam int     TOTAL      = DISPLAY + FRONT + SYNC + BACK;
    localparam coord_t LAST       = coord_t'(TOTAL - 1);
    localparam coord_t SYNC_FIRST = coord_t'(DISPLAY + FRONT);
    localparam coord_t SYNC_LAST  = coord_t'(DISPLAY + FRONT + SYNC - 1);
    localparam coord_t DISP_END   = coord_t'(DISPLAY);

    coord_t pos_nxt;
    logic   sync_nxt;

    always_comb begin
        pos_nxt = pos;
        wrap    = en && (pos == LAST);
        if (en) begin
            pos_nxt = (pos == LAST) ? '0 : pos + 10'd1;
        end
        sync_nxt = ((pos_nxt >= SYNC_FIRST) && (pos_nxt <= SYNC_LAST)) ? SYNC_ACTIVE : SYNC_IDLE;
    end

    assign active = (pos < DISP_END);

    // NOTE: sync is decoded from pos_nxt, so the flop lands on the same edge as the
    // counter it describes -- zero latency and no combinational glitches on the pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos  <= '0;
            sync <= SYNC_IDLE;
        end else begin
            pos  <= pos_nxt;
            sync <= sync_nxt;
        end
    end

endmodule

// File: rtl/hvsync_generator.sv
// VGA-style raster timing generator: horizontal axis counts pixels, vertical axis counts lines.
// Defining HVSYNC_ACTIVE_HIGH_EN inverts hsync/vsync polarity.
module hvsync_generator
    import hvsync_pkg::*;
#(
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    logic h_active;
    logic v_active;
    logic h_wrap;

    hvsync_axis #(
        .DISPLAY (H_DISPLAY),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (1'b1),
        .pos    (hpos),
        .sync   (hsync),
        .active (h_active),
        .wrap   (h_wrap)
    );

    // The vertical axis advances only on the clock where the line wraps.
    hvsync_axis #(
        .DISPLAY (V_DISPLAY),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (h_wrap),
        .pos    (vpos),
        .sync   (vsync),
        .active (v_active),
        .wrap   ()
    );

    assign display_on = h_active && v_active;

endmodule

// File: tb/tb_hvsync_generator.sv
// Directed bench: default-timing instance for line-level checks, plus a shrunken-timing
// instance (16 x 12) so that full frames and the vsync window fit in a short run.
module tb_hvsync_generator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       hsync, vsync, display_on;
    logic [9:0] hpos, vpos;
    logic       s_hsync, s_vsync, s_display_on;
    logic [9:0] s_hpos, s_vpos;

    int total  = 0;
    int passed = 0;

`ifdef HVSYNC_ACTIVE_HIGH_EN
    localparam logic IDLE = 1'b0;
`else
    localparam logic IDLE = 1'b1;
`endif
    localparam logic ACT = ~IDLE;

    always #5 clk = ~clk;

    hvsync_generator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsync      (hsync),
        .vsync      (vsync),
        .display_on (display_on),
        .hpos       (hpos),
        .vpos       (vpos)
    );

    // Small raster: H = 8+2+3+3 = 16, V = 6+2+2+2 = 12, frame = 192 clocks.
    hvsync_generator #(
        .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
        .V_DISPLAY (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (2)
    ) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsync      (s_hsync),
        .vsync      (s_vsync),
        .display_on (s_display_on),
        .hpos       (s_hpos),
        .vpos       (s_vpos)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int exp_h, exp_v;
        int max_h, max_v;

        // Power-up reset, then a partial line before a mid-line async reset.
        tick(2);
        check("por_hpos", 32'(hpos), 0);
        check("por_hsync", 32'(hsync), 32'(IDLE));
        rst_n = 1'b1;
        tick(123);
        check("run_hpos_123", 32'(hpos), 123);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_hpos", 32'(hpos), 0);
        check("async_rst_vpos", 32'(vpos), 0);
        check("async_rst_hsync", 32'(hsync), 32'(IDLE));
        check("async_rst_vsync", 32'(vsync), 32'(IDLE));
        check("async_rst_display_on", 32'(display_on), 1);
        tick(3);
        check("held_rst_hpos", 32'(hpos), 0);

        // Release on a falling edge: after n rising edges hpos == n.
        rst_n = 1'b1;
        tick(639);
        check("h639_hpos", 32'(hpos), 639);
        check("h639_display_on", 32'(display_on), 1);
        tick(1);
        check("h640_hpos", 32'(hpos), 640);
        check("h640_display_on", 32'(display_on), 0);
        tick(15);
        check("h655_hsync", 32'(hsync), 32'(IDLE));
        tick(1);
        check("h656_hsync", 32'(hsync), 32'(ACT));
        tick(95);
        check("h751_hpos", 32'(hpos), 751);
        check("h751_hsync", 32'(hsync), 32'(ACT));
        tick(1);
        check("h752_hsync", 32'(hsync), 32'(IDLE));
        tick(47);
        check("h799_hpos", 32'(hpos), 799);
        check("h799_vpos", 32'(vpos), 0);
        tick(1);
        check("wrap_hpos", 32'(hpos), 0);
        check("wrap_vpos", 32'(vpos), 1);
        check("wrap_vsync", 32'(vsync), 32'(IDLE));

        // Second full line on the default instance, checked every clock.
        for (int c = 0; c < 800; c++) begin
            check("line_hpos", 32'(hpos), 32'(c));
            check("line_hsync", 32'(hsync), (c >= 656 && c <= 751) ? 32'(ACT) : 32'(IDLE));
            check("line_display_on", 32'(display_on), (c < 640) ? 32'd1 : 32'd0);
            tick(1);
        end
        check("line2_vpos", 32'(vpos), 2);

        // Fresh reset, then two full small frames checked every clock.
        @(negedge clk) rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        max_h = 0;
        max_v = 0;
        for (int c = 0; c <= 384; c++) begin
            exp_h = c % 16;
            exp_v = (c / 16) % 12;
            check("s_hpos", 32'(s_hpos), 32'(exp_h));
            check("s_vpos", 32'(s_vpos), 32'(exp_v));
            check("s_hsync", 32'(s_hsync), (exp_h >= 10 && exp_h <= 12) ? 32'(ACT) : 32'(IDLE));
            check("s_vsync", 32'(s_vsync), (exp_v >= 8 && exp_v <= 9) ? 32'(ACT) : 32'(IDLE));
            check("s_display_on", 32'(s_display_on), (exp_h < 8 && exp_v < 6) ? 32'd1 : 32'd0);
            if (int'(hpos) > max_h) max_h = int'(hpos);
            if (int'(vpos) > max_v) max_v = int'(vpos);
            tick(1);
        end
        check("s_frame_hpos", 32'(s_hpos), 1);
        check("s_frame_vpos", 32'(s_vpos), 0);
        check("dflt_hpos_bound", (max_h < 800) ? 32'd1 : 32'd0, 1);
        check("dflt_vpos_bound", (max_v < 525) ? 32'd1 : 32'd0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
